// File: rtl/sbqm_controller.sv
// Single-bank queue management controller: counts customers between an entry and an
// exit photocell and registers a wait-time estimate. Optional SBQM_ALARM_EN adds a sticky overflow alarm.
module sbqm_controller #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Fphoto,
    input  logic         Bphoto,
    input  logic [1:0]   Tcount,
    input  logic [N+1:0] lut_data,
    output logic [N+1:0] lut_addr,
    output logic [N-1:0] Pcount,
    output logic [N+1:0] Wtime,
    output logic         full_flag,
    output logic         empty_flag
`ifdef SBQM_ALARM_EN
    ,
    output logic         alarm
`endif
);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    localparam logic [N-1:0] CNT_MAX  = '1;
    localparam logic [N-1:0] CNT_ZERO = '0;

    logic         f_s1_q, f_s2_q, f_d_q;
    logic         b_s1_q, b_s2_q, b_d_q;
    logic [1:0]   state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic         empty_q, full_q;
    logic [N+1:0] wtime_q;
    logic         f_evt, b_evt;
    logic         entry_only, exit_only;

    // Occupancy class implied by a count; keeps state and count consistent by construction.
    function automatic logic [1:0] state_of(input logic [N-1:0] cnt);
        if (cnt == CNT_ZERO)
            return ST_EMPTY;
        else if (cnt == CNT_MAX)
            return ST_FULL;
        else
            return ST_PARTIAL;
    endfunction

    // Two-flop synchronizers followed by a history flop; events fire on the falling edge (release).
    always_ff @(posedge clk) begin
        if (rst) begin
            f_s1_q <= 1'b0;
            f_s2_q <= 1'b0;
            f_d_q  <= 1'b0;
            b_s1_q <= 1'b0;
            b_s2_q <= 1'b0;
            b_d_q  <= 1'b0;
        end else begin
            f_s1_q <= Fphoto;
            f_s2_q <= f_s1_q;
            f_d_q  <= f_s2_q;
            b_s1_q <= Bphoto;
            b_s2_q <= b_s1_q;
            b_d_q  <= b_s2_q;
        end
    end

    assign f_evt      = f_d_q & ~f_s2_q;
    assign b_evt      = b_d_q & ~b_s2_q;
    assign entry_only = f_evt & ~b_evt;
    assign exit_only  = b_evt & ~f_evt;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (entry_only) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = state_of(cnt_d);
                end
            end
            ST_PARTIAL: begin
                if (entry_only) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = state_of(cnt_d);
                end else if (exit_only) begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = state_of(cnt_d);
                end
            end
            ST_FULL: begin
                if (exit_only) begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = state_of(cnt_d);
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            cnt_q   <= CNT_ZERO;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            wtime_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            empty_q <= (state_d == ST_EMPTY);
            full_q  <= (state_d == ST_FULL);
            wtime_q <= lut_data;
        end
    end

`ifdef SBQM_ALARM_EN
    logic alarm_q, alarm_d;

    // Sticky: an entry attempt while full sets it; only a real decrement clears it.
    always_comb begin
        alarm_d = alarm_q;
        if (entry_only && (state_q == ST_FULL))
            alarm_d = 1'b1;
        else if (exit_only && (state_q != ST_EMPTY))
            alarm_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            alarm_q <= 1'b0;
        else
            alarm_q <= alarm_d;
    end

    assign alarm = alarm_q;
`endif

    assign lut_addr   = {cnt_q, Tcount};
    assign Pcount     = cnt_q;
    assign Wtime      = wtime_q;
    assign empty_flag = empty_q;
    assign full_flag  = full_q;

endmodule

// File: tb/tb_sbqm_controller.sv
// Directed bench for sbqm_controller with a behavioural wait-time table:
// wait = Pcount * (4 - Tcount), or 0 when no teller is open.
module tb_sbqm_controller;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         Fphoto, Bphoto;
    logic [1:0]   Tcount;
    logic [N+1:0] lut_data, lut_addr, Wtime;
    logic [N-1:0] Pcount;
    logic         full_flag, empty_flag;
`ifdef SBQM_ALARM_EN
    logic         alarm;
`endif

    int checks = 0;
    int errors = 0;

    sbqm_controller #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .Fphoto     (Fphoto),
        .Bphoto     (Bphoto),
        .Tcount     (Tcount),
        .lut_data   (lut_data),
        .lut_addr   (lut_addr),
        .Pcount     (Pcount),
        .Wtime      (Wtime),
        .full_flag  (full_flag),
        .empty_flag (empty_flag)
`ifdef SBQM_ALARM_EN
        ,
        .alarm      (alarm)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        logic [N-1:0] p;
        logic [1:0]   t;
        p = lut_addr[N+1:2];
        t = lut_addr[1:0];
        if (t == 2'd0)
            lut_data = '0;
        else
            lut_data = (N+2)'(p * (3'd4 - {1'b0, t}));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hold the entry cell for 4 cycles, release, and wait until the count update has landed.
    task automatic f_pulse();
        Fphoto = 1'b1;
        tick(4);
        Fphoto = 1'b0;
        tick(3);
    endtask

    task automatic b_pulse();
        Bphoto = 1'b1;
        tick(4);
        Bphoto = 1'b0;
        tick(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        Fphoto = 1'b0;
        Bphoto = 1'b0;
        Tcount = 2'd1;
        do_reset();
        chk("reset_pcount", 32'(Pcount), 0);
        chk("reset_empty", 32'(empty_flag), 1);
        chk("reset_full", 32'(full_flag), 0);
        chk("reset_wtime", 32'(Wtime), 0);
        chk("reset_lut_addr", 32'(lut_addr), 1);
`ifdef SBQM_ALARM_EN
        chk("reset_alarm", 32'(alarm), 0);
`endif

        // Three arrivals with one teller open.
        f_pulse();
        chk("arrive1_pcount", 32'(Pcount), 1);
        chk("arrive1_empty", 32'(empty_flag), 0);
        f_pulse();
        f_pulse();
        chk("arrive3_pcount", 32'(Pcount), 3);
        chk("arrive3_empty", 32'(empty_flag), 0);
        tick(1);
        chk("arrive3_wtime", 32'(Wtime), 9);

        // Teller change: address follows at once, Wtime one edge later.
        Tcount = 2'd2;
        #1;
        chk("tcount_lut_addr", 32'(lut_addr), 14);
        chk("tcount_wtime_old", 32'(Wtime), 9);
        tick(1);
        chk("tcount_wtime_new", 32'(Wtime), 6);

        // Exact exit latency: first low sample is edge k, count at k+2, Wtime at k+3.
        Bphoto = 1'b1;
        tick(4);
        Bphoto = 1'b0;
        tick(2);
        chk("exit_pcount_k1", 32'(Pcount), 3);
        tick(1);
        chk("exit_pcount_k2", 32'(Pcount), 2);
        chk("exit_wtime_k2", 32'(Wtime), 6);
        tick(1);
        chk("exit_wtime_k3", 32'(Wtime), 4);

        // Fill to saturation, then one more arrival must not wrap.
        Tcount = 2'd1;
        do_reset();
        for (int i = 0; i < 7; i++) f_pulse();
        chk("fill7_pcount", 32'(Pcount), 7);
        chk("fill7_full", 32'(full_flag), 1);
        f_pulse();
        chk("fill8_pcount", 32'(Pcount), 7);
        chk("fill8_full", 32'(full_flag), 1);
`ifdef SBQM_ALARM_EN
        chk("fill8_alarm", 32'(alarm), 1);
`endif
        b_pulse();
        chk("unfill_pcount", 32'(Pcount), 6);
        chk("unfill_full", 32'(full_flag), 0);
`ifdef SBQM_ALARM_EN
        chk("unfill_alarm", 32'(alarm), 0);
`endif

        // Exit while empty is ignored.
        do_reset();
        b_pulse();
        chk("underflow_pcount", 32'(Pcount), 0);
        chk("underflow_empty", 32'(empty_flag), 1);

        // Simultaneous release at Pcount=4 leaves the count alone.
        for (int i = 0; i < 4; i++) f_pulse();
        chk("four_pcount", 32'(Pcount), 4);
        Fphoto = 1'b1;
        Bphoto = 1'b1;
        tick(4);
        Fphoto = 1'b0;
        Bphoto = 1'b0;
        tick(4);
        chk("simul_pcount", 32'(Pcount), 4);

        // No tellers: the table supplies 0.
        Tcount = 2'd0;
        tick(1);
        chk("tcount0_wtime", 32'(Wtime), 0);

        // Back to empty from PARTIAL via exits.
        for (int i = 0; i < 4; i++) b_pulse();
        chk("drain_pcount", 32'(Pcount), 0);
        chk("drain_empty", 32'(empty_flag), 1);

        // Entry cell held across a reset counts once, on release.
        Tcount = 2'd1;
        f_pulse();
        chk("prereset_pcount", 32'(Pcount), 1);
        Fphoto = 1'b1;
        tick(10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midreset_pcount", 32'(Pcount), 0);
        chk("midreset_empty", 32'(empty_flag), 1);
        tick(9);
        chk("held_pcount", 32'(Pcount), 0);
        Fphoto = 1'b0;
        tick(2);
        chk("release_k1_pcount", 32'(Pcount), 0);
        tick(1);
        chk("release_k2_pcount", 32'(Pcount), 1);
        chk("release_k2_empty", 32'(empty_flag), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
